// File: rtl/qupls4_copydst_sequencer.sv
// qupls4_copydst_sequencer
// Collects ROB entries whose destination must be copied (stomped, skipped, or
// same-group younger than a resolved branch), holds them in a pending set and
// issues up to NCP copy-target micro-ops per cycle over valid/ready ports.
// Also tracks physical registers that stay unavailable until their copy ends.
module qupls4_copydst_sequencer #(
   parameter int ROB_ENTRIES     = 32,
   parameter int PREGS           = 512,
   parameter int NFCU            = 2,
   parameter int NCP             = 2,
   parameter int SN_W            = 8,
   parameter int GRP_W           = 4,
   parameter int SUPPORT_BACKOUT = 0,
   localparam int RW = $clog2(ROB_ENTRIES),
   localparam int PW = $clog2(PREGS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ROB_ENTRIES-1:0]       rob_v,
   input  logic [ROB_ENTRIES*GRP_W-1:0] rob_grp,
   input  logic [ROB_ENTRIES*SN_W-1:0]  rob_sn,
   input  logic [ROB_ENTRIES*PW-1:0]    rob_nrd,
   input  logic [ROB_ENTRIES-1:0]       rob_br,
   input  logic [ROB_ENTRIES-1:0]       rob_cjb,
   input  logic [ROB_ENTRIES-1:0]       stomp,
   input  logic [ROB_ENTRIES-1:0]       skip_list,
   input  logic [NFCU-1:0]              fcu_idv,
   input  logic [NFCU*RW-1:0]           fcu_id,
   input  logic [NFCU-1:0]              fcu_resolved,
   input  logic [NFCU-1:0]              fcu_takb,
   input  logic                         flush,
   input  logic [NCP-1:0]               cp_ready,
   input  logic [NCP-1:0]               cp_done_v,
   input  logic [NCP*PW-1:0]            cp_done_preg,
   output logic [NCP-1:0]               cp_valid,
   output logic [NCP*RW-1:0]            cp_id,
   output logic [NCP*PW-1:0]            cp_preg,
   output logic [ROB_ENTRIES-1:0]       copydst,
   output logic [PREGS-1:0]             unavail_list,
   output logic                         busy
);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_t;

   state_t                 state, state_nx;
   logic [ROB_ENTRIES-1:0] pending_q, pend_nx;
   logic [ROB_ENTRIES-1:0] set_v, clr_v, uset_src, acc, drop, avail;
   logic [PREGS-1:0]       unavail_q, unav_nx, un_set, un_clr;

   assign copydst      = pending_q;
   assign unavail_list = unavail_q;

   // Per-cycle marks: set/clear of pending entries and which marks reserve a preg.
   always_comb begin
      set_v    = '0;
      clr_v    = '0;
      uset_src = '0;
      for (int c = 0; c < NFCU; c++) begin : g_ch
         logic [RW-1:0]    bid;
         logic [GRP_W-1:0] bgrp;
         logic [SN_W-1:0]  bsn;
         logic             tk, nt, sk;
         bid  = fcu_id[c*RW +: RW];
         bgrp = rob_grp[int'(bid)*GRP_W +: GRP_W];
         bsn  = rob_sn[int'(bid)*SN_W +: SN_W];
         tk   = fcu_idv[c] & ((rob_br[bid] & fcu_takb[c]) | ((SUPPORT_BACKOUT != 0) & rob_cjb[bid]));
         nt   = fcu_idv[c] & rob_br[bid] & ~fcu_takb[c] & (SUPPORT_BACKOUT == 0);
         sk   = fcu_idv[c] & fcu_resolved[c];
         for (int n = 0; n < ROB_ENTRIES; n++) begin : g_ent
            logic yng;
            yng = (rob_grp[n*GRP_W +: GRP_W] == bgrp) && (rob_sn[n*SN_W +: SN_W] > bsn);
            if (sk && skip_list[n]) begin
               set_v[n]    = 1'b1;
               uset_src[n] = 1'b1;
            end
            if (tk && yng) begin
               set_v[n] = 1'b1;
               if (SUPPORT_BACKOUT != 0) uset_src[n] = 1'b1;
            end
            if (nt && yng) clr_v[n] = 1'b1;
         end
      end
      if (SUPPORT_BACKOUT == 0) set_v = set_v | stomp;
      // marks seen during the flush cycle are discarded
      if (state == S_FLUSH) begin
         set_v    = '0;
         clr_v    = '0;
         uset_src = '0;
      end
   end

   // Issue: lowest-indexed pending entries go to ports 0..NCP-1 in ascending order.
   always_comb begin
      avail    = (state == S_FLUSH) ? '0 : pending_q;
      cp_valid = '0;
      cp_id    = '0;
      cp_preg  = '0;
      acc      = '0;
      for (int k = 0; k < NCP; k++) begin : g_port
         logic          found;
         logic [RW-1:0] sel;
         found = 1'b0;
         sel   = '0;
         for (int n = 0; n < ROB_ENTRIES; n++) begin
            if (!found && avail[n]) begin
               found = 1'b1;
               sel   = RW'(n);
            end
         end
         if (found) begin
            avail[sel]            = 1'b0;
            cp_valid[k]           = 1'b1;
            cp_id[k*RW +: RW]     = sel;
            cp_preg[k*PW +: PW]   = rob_nrd[int'(sel)*PW +: PW];
            if (cp_ready[k]) acc[sel] = 1'b1;
         end
      end
   end

   // Next pending set and unavailable-preg set; sets beat clears, flush beats all.
   always_comb begin
      drop    = pending_q & ~rob_v;
      pend_nx = (pending_q & ~clr_v & ~acc & ~drop) | set_v;
      un_set  = '0;
      un_clr  = '0;
      for (int k = 0; k < NCP; k++)
         if (cp_done_v[k]) un_clr[cp_done_preg[k*PW +: PW]] = 1'b1;
      for (int n = 0; n < ROB_ENTRIES; n++) begin
         if (drop[n])     un_clr[rob_nrd[n*PW +: PW]] = 1'b1;
         if (uset_src[n]) un_set[rob_nrd[n*PW +: PW]] = 1'b1;
      end
      unav_nx = (unavail_q & ~un_clr) | un_set;
      if (flush) begin
         pend_nx = '0;
         unav_nx = '0;
      end
   end

   // Pending and unavailable registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         unavail_q <= '0;
      end else begin
         pending_q <= pend_nx;
         unavail_q <= unav_nx;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state;
      if (flush) state_nx = S_FLUSH;
      else begin
         case (state)
            S_IDLE:  if (|set_v)      state_nx = S_DRAIN;
            S_DRAIN: if (pend_nx == '0) state_nx = S_IDLE;
            S_FLUSH: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // FSM outputs.
   always_comb begin
      busy = (state != S_IDLE);
   end

endmodule

// File: tb/tb_qupls4_copydst_sequencer.sv
// Directed bench for qupls4_copydst_sequencer: one stomp-driven instance (u0)
// and one backout instance (u1) share all inputs.
module tb_qupls4_copydst_sequencer;
   localparam int RE = 32, PR = 512, NF = 2, NC = 2, RW = 5, PW = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [RE-1:0]    rob_v, rob_br, rob_cjb, stomp, skip_list;
   logic [RE*4-1:0]  rob_grp;
   logic [RE*8-1:0]  rob_sn;
   logic [RE*PW-1:0] rob_nrd;
   logic [NF-1:0]    fcu_idv, fcu_resolved, fcu_takb;
   logic [NF*RW-1:0] fcu_id;
   logic             flush;
   logic [NC-1:0]    cp_ready, cp_done_v;
   logic [NC*PW-1:0] cp_done_preg;

   logic [NC-1:0] v0, v1;
   logic [NC*RW-1:0] id0, id1;
   logic [NC*PW-1:0] pr0, pr1;
   logic [RE-1:0] cd0, cd1;
   logic [PR-1:0] un0, un1;
   logic b0, b1;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_id[6] = '{2, 3, 5, 8, 9, 12};

   always #5 clk = ~clk;

   qupls4_copydst_sequencer #(.SUPPORT_BACKOUT(0)) u0 (
      .clk(clk), .rst(rst), .rob_v(rob_v), .rob_grp(rob_grp), .rob_sn(rob_sn),
      .rob_nrd(rob_nrd), .rob_br(rob_br), .rob_cjb(rob_cjb), .stomp(stomp),
      .skip_list(skip_list), .fcu_idv(fcu_idv), .fcu_id(fcu_id),
      .fcu_resolved(fcu_resolved), .fcu_takb(fcu_takb), .flush(flush),
      .cp_ready(cp_ready), .cp_done_v(cp_done_v), .cp_done_preg(cp_done_preg),
      .cp_valid(v0), .cp_id(id0), .cp_preg(pr0), .copydst(cd0),
      .unavail_list(un0), .busy(b0));

   qupls4_copydst_sequencer #(.SUPPORT_BACKOUT(1)) u1 (
      .clk(clk), .rst(rst), .rob_v(rob_v), .rob_grp(rob_grp), .rob_sn(rob_sn),
      .rob_nrd(rob_nrd), .rob_br(rob_br), .rob_cjb(rob_cjb), .stomp(stomp),
      .skip_list(skip_list), .fcu_idv(fcu_idv), .fcu_id(fcu_id),
      .fcu_resolved(fcu_resolved), .fcu_takb(fcu_takb), .flush(flush),
      .cp_ready(cp_ready), .cp_done_v(cp_done_v), .cp_done_preg(cp_done_preg),
      .cp_valid(v1), .cp_id(id1), .cp_preg(pr1), .copydst(cd1),
      .unavail_list(un1), .busy(b1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rob_v = '1; rob_br = '0; rob_cjb = '0; stomp = '0; skip_list = '0;
      rob_grp = '0; rob_sn = '0;
      for (int n = 0; n < RE; n++) rob_nrd[n*PW +: PW] = PW'(100 + n);
      fcu_idv = '0; fcu_resolved = '0; fcu_takb = '0; fcu_id = '0;
      flush = 1'b0; cp_ready = '0; cp_done_v = '0; cp_done_preg = '0;

      // reset state
      #3;
      chk("rst_copydst", cd0, 0);
      chk("rst_valid", v0, 0);
      chk("rst_busy", b0, 0);
      chk("rst_unavail", |un0, 0);
      @(negedge clk); rst = 1'b0;

      // async reset mid-drain with 5 pending skip entries
      skip_list = 32'h1F0; fcu_idv = 2'b01; fcu_resolved = 2'b01;
      @(negedge clk); skip_list = '0; fcu_idv = '0; fcu_resolved = '0;
      chk("t1_pend", cd0, 32'h1F0);
      chk("t1_busy", b0, 1);
      chk("t1_unav104", un0[104], 1);
      #2 rst = 1'b1;
      #1;
      chk("t1_rst_copydst", cd0, 0);
      chk("t1_rst_valid", v0, 0);
      chk("t1_rst_busy", b0, 0);
      chk("t1_rst_unavail", |un0, 0);
      #1 rst = 1'b0;

      // six stomped entries, only port 0 ready
      @(negedge clk); stomp = 32'h132C; cp_ready = 2'b01;
      @(negedge clk); stomp = '0;
      chk("t4_pend", cd0, 32'h132C);
      chk("t4_valid", v0, 2'b11);
      chk("t4_port1", id0[9:5], 3);
      chk("t4_bk_ignores_stomp", cd1, 0);
      for (int i = 0; i < 6; i++) begin
         chk("t4_id", id0[4:0], exp_id[i]);
         if (i == 5) chk("t4_last_valid", v0, 2'b01);
         @(negedge clk);
      end
      chk("t4_idle", b0, 0);
      chk("t4_empty", cd0, 0);
      cp_ready = '0;

      // backout taken branch at id 3
      rob_br[3] = 1'b1;
      rob_grp[3*4 +: 4] = 4'd2; rob_sn[3*8 +: 8] = 8'd10;
      rob_grp[4*4 +: 4] = 4'd2; rob_sn[4*8 +: 8] = 8'd11;
      rob_grp[5*4 +: 4] = 4'd2; rob_sn[5*8 +: 8] = 8'd12;
      rob_grp[6*4 +: 4] = 4'd1; rob_sn[6*8 +: 8] = 8'd13;
      fcu_idv = 2'b01; fcu_id[4:0] = 5'd3; fcu_resolved = 2'b01; fcu_takb = 2'b01;
      @(negedge clk); fcu_idv = '0; fcu_resolved = '0; fcu_takb = '0; fcu_id = '0;
      chk("t2_pend", cd1, 32'h30);
      chk("t2_unav104", un1[104], 1);
      chk("t2_unav105", un1[105], 1);
      chk("t2_unav106", un1[106], 0);
      chk("t2_id0", id1[4:0], 4);
      chk("t2_id1", id1[9:5], 5);
      chk("t2_preg0", pr1[8:0], 104);
      chk("t2_preg1", pr1[17:9], 105);
      chk("t2_nobk_pend", cd0, 32'h30);
      chk("t2_nobk_unav", un0[104], 0);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      @(negedge clk);
      rob_br = '0; rob_grp = '0; rob_sn = '0;

      // not-taken clear versus skip set on entry 7
      rob_br[10] = 1'b1;
      rob_grp[10*4 +: 4] = 4'd3; rob_sn[10*8 +: 8] = 8'd20;
      rob_grp[7*4 +: 4]  = 4'd3; rob_sn[7*8 +: 8]  = 8'd25;
      stomp[7] = 1'b1;
      @(negedge clk); stomp = '0;
      chk("t3_pend7", cd0, 32'h80);
      fcu_idv = 2'b01; fcu_id[4:0] = 5'd10;
      @(negedge clk); fcu_idv = '0;
      chk("t3_clr", cd0, 0);
      chk("t3_clr_idle", b0, 0);
      fcu_idv = 2'b11; fcu_resolved = 2'b10; skip_list[7] = 1'b1;
      @(negedge clk); fcu_idv = '0; fcu_resolved = '0; skip_list = '0; fcu_id = '0;
      chk("t3_set_wins", cd0, 32'h80);
      chk("t3_unav107", un0[107], 1);
      rob_br = '0; rob_grp = '0; rob_sn = '0;

      // flush with unavail bit 40 and a same-cycle completion of 40
      rob_nrd[15*PW +: PW] = 9'd40;
      skip_list[15] = 1'b1; fcu_idv = 2'b10; fcu_resolved = 2'b10;
      @(negedge clk);
      chk("t6_unav40", un0[40], 1);
      chk("t6_pend15", cd0[15], 1);
      cp_done_v = 2'b01; cp_done_preg[8:0] = 9'd40;
      @(negedge clk);
      chk("t6_set_beats_done", un0[40], 1);
      skip_list = '0; fcu_idv = '0; fcu_resolved = '0; flush = 1'b1;
      @(negedge clk); flush = 1'b0; cp_done_v = '0;
      skip_list[15] = 1'b1; fcu_idv = 2'b10; fcu_resolved = 2'b10;
      chk("t6_flush_busy", b0, 1);
      chk("t6_flush_pend", cd0, 0);
      chk("t6_flush_unav", |un0, 0);
      chk("t6_flush_valid", v0, 0);
      @(negedge clk); skip_list = '0; fcu_idv = '0; fcu_resolved = '0;
      chk("t6_idle", b0, 0);
      chk("t6_mark_ignored", cd0, 0);
      chk("t6_unav40_clear", un0[40], 0);
      rob_nrd[15*PW +: PW] = 9'd115;

      // port 0 held while not ready, re-mark on the accept cycle
      stomp = 32'hA00;
      @(negedge clk); stomp = '0;
      for (int i = 0; i < 3; i++) begin
         chk("t5_hold_id", id0[4:0], 9);
         chk("t5_hold_preg", pr0[8:0], 109);
         @(negedge clk);
      end
      cp_ready = 2'b01; stomp[9] = 1'b1;
      #1 chk("t5_accept_id", id0[4:0], 9);
      @(negedge clk); stomp = '0; cp_ready = '0;
      chk("t5_remark_pend", cd0, 32'hA00);
      chk("t5_reissue_id", id0[4:0], 9);
      cp_ready = 2'b11;
      @(negedge clk); cp_ready = '0;
      chk("t5_drained", cd0, 0);
      chk("t5_idle", b0, 0);

      // pending entry whose rob_v drops is discarded and frees its preg
      skip_list[20] = 1'b1; fcu_idv = 2'b10; fcu_resolved = 2'b10;
      @(negedge clk); skip_list = '0; fcu_idv = '0; fcu_resolved = '0;
      chk("drop_pend", cd0, 32'h0010_0000);
      chk("drop_unav_set", un0[120], 1);
      rob_v[20] = 1'b0;
      @(negedge clk); rob_v = '1;
      chk("drop_pend_gone", cd0, 0);
      chk("drop_unav_clr", un0[120], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
